mm_session_ctrl: RTL

- Protocol sequencer for the UART matrix-multiply datapath; runs one full session per host transaction.
- Session flow: detect start byte, take size N (1..3), route N*N bytes of A then B into the matrix memories, pulse the multiplier, stream the result back through uart_tx with a busy handshake.
- Sits between uart_rx/uart_tx, the two matrix_memory instances and Calculator, all on bclk.
- Owns every address counter and all tx byte selection.

---
 rtl/mm_pkg.sv | 29 ++
 rtl/mm_session_ctrl_if.sv | 31 +++
 rtl/mm_tx_sequencer.sv | 113 +++++++++++
 rtl/mm_session_ctrl.sv | 109 ++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the UART matrix-multiply session controller:
// major state codes, grid geometry, result width and internal FSM encodings.
package mm_pkg;

  localparam logic [2:0] ST_IDLE             = 3'b000;
  localparam logic [2:0] ST_RECEIVE_SIZE     = 3'b001;
  localparam logic [2:0] ST_RECEIVE_MATRIX_A = 3'b010;
  localparam logic [2:0] ST_RECEIVE_MATRIX_B = 3'b011;
  localparam logic [2:0] ST_COMPUTE          = 3'b100;
  localparam logic [2:0] ST_SEND_RESULT      = 3'b101;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         MAX_N_DEFAULT     = 3;
  localparam int         GRID_STRIDE       = 3;
  localparam int         RESULT_W          = 144;

  typedef enum logic [2:0] {
    C_IDLE, C_SIZE, C_RECV_A, C_RECV_B, C_START, C_WAIT, C_SEND
  } ctrl_state_e;

  typedef enum logic [1:0] {
    T_IDLE, T_READY, T_GUARD, T_DRAIN
  } tx_state_e;

  function automatic logic [3:0] grid_idx(input logic [1:0] row, input logic [1:0] col);
    return 4'(row) * 4'(GRID_STRIDE) + 4'(col);
  endfunction

endpackage

// File: rtl/mm_session_ctrl_if.sv
// Host-side bundle of the session controller: uart rx/tx, memory write port
// and Calculator handshake. master = the controller, slave = its surroundings.
interface mm_session_ctrl_if;
  logic [7:0]                  rx_data;
  logic                        rx_valid;
  logic                        tx_busy;
  logic                        mult_done;
  logic [mm_pkg::RESULT_W-1:0] mult_result;
  logic                        a_we;
  logic                        b_we;
  logic [3:0]                  wr_addr;
  logic [7:0]                  wr_data;
  logic                        mult_start;
  logic                        tx_start;
  logic [7:0]                  tx_data;
  logic [2:0]                  state;
  logic [1:0]                  matrix_size;
  logic                        err;

  modport master (
    input  rx_data, rx_valid, tx_busy, mult_done, mult_result,
    output a_we, b_we, wr_addr, wr_data, mult_start, tx_start, tx_data,
           state, matrix_size, err
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, mult_done, mult_result,
    input  a_we, b_we, wr_addr, wr_data, mult_start, tx_start, tx_data,
           state, matrix_size, err
  );
endinterface

// File: rtl/mm_tx_sequencer.sv
// Streams the latched 3x3 result grid to uart_tx, low byte first, row-major over N x N.
// MM_CHECKSUM_EN appends a modulo-256 sum of all result bytes as a trailer.
module mm_tx_sequencer
  import mm_pkg::*;
(
  input  logic                bclk,
  input  logic                rst,
  input  logic                go,
  input  logic [1:0]          size,
  input  logic [RESULT_W-1:0] result,
  input  logic                tx_busy,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  output logic                done
);

  tx_state_e  cur, nxt;
  logic [1:0] row, col;
  logic       hi;
  logic       guard_cnt;
  logic       last_elem, final_byte, advance, step;
  logic [7:0] byte_sel;

  assign last_elem = (row == size - 2'd1) && (col == size - 2'd1) && hi;
  assign byte_sel  = result[{grid_idx(row, col), hi, 3'b000} +: 8];
  assign advance   = ((cur == T_GUARD) && !tx_busy && guard_cnt) ||
                     ((cur == T_DRAIN) && !tx_busy);

`ifdef MM_CHECKSUM_EN
  logic [7:0] sum;
  logic       trailer;
  assign final_byte = trailer;
  assign tx_data    = trailer ? sum : byte_sel;
  assign step       = advance && !last_elem;
`else
  assign final_byte = last_elem;
  assign tx_data    = byte_sel;
  assign step       = advance;
`endif

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
  always_ff @(posedge bclk) begin
    if (rst) cur <= T_IDLE;
    else     cur <= nxt;
  end

  // NOTE: nxt gets a default first so no latch is inferred.
  always_comb begin
    nxt = cur;
    case (cur)
      T_IDLE:  if (go) nxt = T_READY;
      T_READY: if (!tx_busy) nxt = T_GUARD;
      // Busy seen -> wait for it to drop; two quiet cycles -> byte counts as sent.
      T_GUARD: if (tx_busy) nxt = T_DRAIN;
               else if (guard_cnt) nxt = final_byte ? T_IDLE : T_READY;
      T_DRAIN: if (!tx_busy) nxt = final_byte ? T_IDLE : T_READY;
      default: nxt = T_IDLE;
    endcase
  end

  always_comb begin
    tx_start = (cur == T_READY) && !tx_busy && !rst;
    done     = advance && final_byte;
  end

  always_ff @(posedge bclk) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      hi        <= 1'b0;
      guard_cnt <= 1'b0;
`ifdef MM_CHECKSUM_EN
      sum       <= '0;
      trailer   <= 1'b0;
`endif
    end else begin
      if (go) begin
        row <= '0;
        col <= '0;
        hi  <= 1'b0;
`ifdef MM_CHECKSUM_EN
        sum     <= '0;
        trailer <= 1'b0;
`endif
      end
      if (tx_start) begin
        guard_cnt <= 1'b0;
`ifdef MM_CHECKSUM_EN
        if (!trailer) sum <= sum + byte_sel;
`endif
      end else if (cur == T_GUARD) begin
        guard_cnt <= 1'b1;
      end
`ifdef MM_CHECKSUM_EN
      if (advance && last_elem) trailer <= 1'b1;
`endif
      if (step) begin
        if (!hi) begin
          hi <= 1'b1;
        end else begin
          hi <= 1'b0;
          if (col == size - 2'd1) begin
            col <= '0;
            row <= row + 2'd1;
          end else begin
            col <= col + 2'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/mm_session_ctrl.sv
// Session sequencer for the UART matrix multiplier: sync byte, size, A, B,
// multiply, result stream. Optional result checksum trailer: MM_CHECKSUM_EN.
module mm_session_ctrl
  import mm_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int         MAX_N     = MAX_N_DEFAULT
) (
  input  logic              bclk,
  input  logic              rst,
  mm_session_ctrl_if.master bus
);

  ctrl_state_e         cur, nxt;
  logic [1:0]          n_q, row, col;
  logic                err_q;
  logic [RESULT_W-1:0] result_q;
  logic                size_ok, wr_fire, last_cell, go, seq_done;
  logic                seq_tx_start;
  logic [7:0]          seq_tx_data;

  assign size_ok   = (bus.rx_data != 8'd0) && (bus.rx_data <= 8'(MAX_N));
  // An rx byte in flight during rst is dropped, not written.
  assign wr_fire   = bus.rx_valid && !rst && ((cur == C_RECV_A) || (cur == C_RECV_B));
  assign last_cell = (row == n_q - 2'd1) && (col == n_q - 2'd1);
  assign go        = (cur == C_WAIT) && bus.mult_done;

  always_ff @(posedge bclk) begin
    if (rst) cur <= C_IDLE;
    else     cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      C_IDLE:   if (bus.rx_valid && bus.rx_data == SYNC_BYTE) nxt = C_SIZE;
      C_SIZE:   if (bus.rx_valid) nxt = size_ok ? C_RECV_A : C_IDLE;
      C_RECV_A: if (bus.rx_valid && last_cell) nxt = C_RECV_B;
      C_RECV_B: if (bus.rx_valid && last_cell) nxt = C_START;
      C_START:  nxt = C_WAIT;
      C_WAIT:   if (bus.mult_done) nxt = C_SEND;
      C_SEND:   if (seq_done) nxt = C_IDLE;
      default:  nxt = C_IDLE;
    endcase
  end

  always_comb begin
    bus.a_we        = wr_fire && (cur == C_RECV_A);
    bus.b_we        = wr_fire && (cur == C_RECV_B);
    bus.wr_addr     = wr_fire ? grid_idx(row, col) : 4'd0;
    bus.wr_data     = wr_fire ? bus.rx_data : 8'd0;
    bus.mult_start  = (cur == C_START) && !rst;
    bus.tx_start    = seq_tx_start;
    bus.tx_data     = seq_tx_data;
    bus.matrix_size = n_q;
    bus.err         = err_q;
    case (cur)
      C_SIZE:          bus.state = ST_RECEIVE_SIZE;
      C_RECV_A:        bus.state = ST_RECEIVE_MATRIX_A;
      C_RECV_B:        bus.state = ST_RECEIVE_MATRIX_B;
      C_START, C_WAIT: bus.state = ST_COMPUTE;
      C_SEND:          bus.state = ST_SEND_RESULT;
      default:         bus.state = ST_IDLE;
    endcase
  end

  // NOTE: the result register is reset too, so tx_data reads 0 after rst.
  always_ff @(posedge bclk) begin
    if (rst) begin
      n_q      <= '0;
      row      <= '0;
      col      <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      if (cur == C_SIZE && bus.rx_valid) begin
        if (size_ok) begin
          n_q <= bus.rx_data[1:0];
          row <= '0;
          col <= '0;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (wr_fire) begin
        if (col == n_q - 2'd1) begin
          col <= '0;
          row <= last_cell ? 2'd0 : row + 2'd1;
        end else begin
          col <= col + 2'd1;
        end
      end
      if (go) result_q <= bus.mult_result;
    end
  end

  mm_tx_sequencer u_tx_seq (
    .bclk     (bclk),
    .rst      (rst),
    .go       (go),
    .size     (n_q),
    .result   (result_q),
    .tx_busy  (bus.tx_busy),
    .tx_start (seq_tx_start),
    .tx_data  (seq_tx_data),
    .done     (seq_done)
  );

endmodule
